mt9v034_pixel_packer: RTL and testbench

- Single-clock successor to the camera pixel input path.
- Accepts an unthrottled camera pixel stream that has already been synchronised into the AXI clock domain. Input has valid/last/user and no ready.
- Packs PIXELS_PER_BEAT pixels per AXI4-Stream beat, buffers the beats in an internal FIFO, and drives a backpressured master towards VDMA.
- Detects overflow, drops the remainder of the corrupted frame and resynchronises on the next start-of-frame.

---
 rtl/mt9v034_pkg.sv | 19 +
 rtl/pixel_beat_fifo.sv | 85 ++++++++
 rtl/mt9v034_pixel_packer.sv | 190 +++++++++++++++++++
 tb/tb_mt9v034_pixel_packer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mt9v034_pkg.sv
// Shared types and helpers for the MT9V034 pixel packer.
//   state_e    : packer state (SYNC wait for frame start, PACK, DROP after overflow)
//   LANE_W     : width of one pixel lane in the output beat
//   fifo_ptr_w : count-pointer width for a FIFO of the given depth (one extra wrap bit)
package mt9v034_pkg;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    PACK = 2'd1,
    DROP = 2'd2
  } state_e;

  localparam int LANE_W = 16;

  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/pixel_beat_fifo.sv
// First-word-fall-through beat FIFO with a registered output stage.
// Total capacity (memory plus output register) is DEPTH entries. A push that
// coincides with a pop while full is accepted because the pop is taken first.
// Ports:
//   clk_i, rst_n_i     clock, asynchronous active-low reset
//   push_i/push_data_i write request and word
//   push_lost_o        push refused because the FIFO is full
//   rd_ready_i         consumer ready
//   rd_valid_o/rd_data_o  head word, held stable until taken
module pixel_beat_fifo
  import mt9v034_pkg::*;
#(
  parameter int DATA_W = 74,
  parameter int DEPTH  = 512
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  output logic              push_lost_o,
  input  logic              rd_ready_i,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam int PW = fifo_ptr_w(DEPTH);
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] MEM_MAX = PW'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, mem_cnt;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              pop, full, accept, out_free, bypass, mem_wr;

  // The output register is always refilled first, so the memory only holds
  // entries while the output register is occupied.
  assign mem_cnt     = wr_ptr_q - rd_ptr_q;
  assign pop         = out_valid_q & rd_ready_i;
  assign full        = out_valid_q & (mem_cnt == MEM_MAX);
  assign accept      = push_i & (~full | pop);
  assign push_lost_o = push_i & full & ~pop;
  assign out_free    = ~out_valid_q | pop;
  assign bypass      = out_free & (mem_cnt == '0);
  assign mem_wr      = accept & ~bypass;

  always_comb begin
    wr_ptr_d    = wr_ptr_q + PW'(mem_wr);
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q & ~pop;
    out_data_d  = out_data_q;
    if (out_free) begin
      if (mem_cnt != '0) begin
        out_data_d  = mem_q[rd_ptr_q[AW-1:0]];
        out_valid_d = 1'b1;
        rd_ptr_d    = rd_ptr_q + PW'(1);
      end else if (accept) begin
        out_data_d  = push_data_i;
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_wr) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

  assign rd_valid_o = out_valid_q;
  assign rd_data_o  = out_data_q;

endmodule

// File: rtl/mt9v034_pixel_packer.sv
// Packs an unthrottled camera pixel stream into AXI4-Stream beats of
// PIXELS_PER_BEAT 16-bit lanes, buffers them and drives a backpressured master.
// On FIFO overflow the rest of the frame is dropped until the next tuser pixel.
// Ports:
//   axi4sclk, axi4s_resetn      clock, asynchronous active-low reset
//   s_axis_*                    pixel input (valid/data/last/user, no ready)
//   m_axis_*                    packed beat output towards VDMA
//   overflow                    one-cycle pulse when a beat is lost
//   dropped_frames              saturating count of truncated frames
// Optional (macro MT9V034_PIXEL_PACKER_LINE_CHECK_EN):
//   cfg_line_pixels             expected pixels per line, 0 disables the check
//   line_length_err             pulse the cycle after a tlast with a wrong count
//
// state | meaning
// SYNC  | waiting for the first tuser pixel after reset
// PACK  | filling beats from the pixel stream
// DROP  | frame corrupted by overflow, waiting for the next tuser pixel
module mt9v034_pixel_packer
  import mt9v034_pkg::*;
#(
  parameter int PIXEL_WIDTH     = 10,
  parameter int PIXELS_PER_BEAT = 4,
  parameter int FIFO_DEPTH      = 512
) (
  input  logic                                axi4sclk,
  input  logic                                axi4s_resetn,
  input  logic                                s_axis_tvalid,
  input  logic [PIXEL_WIDTH-1:0]              s_axis_tdata,
  input  logic                                s_axis_tlast,
  input  logic                                s_axis_tuser,
  input  logic                                m_axis_tready,
  output logic                                m_axis_tvalid,
  output logic [LANE_W*PIXELS_PER_BEAT-1:0]   m_axis_tdata,
  output logic [2*PIXELS_PER_BEAT-1:0]        m_axis_tkeep,
  output logic                                m_axis_tlast,
  output logic                                m_axis_tuser,
  output logic                                overflow,
  output logic [15:0]                         dropped_frames
`ifdef MT9V034_PIXEL_PACKER_LINE_CHECK_EN
  ,
  input  logic [11:0]                         cfg_line_pixels,
  output logic                                line_length_err
`endif
);

  localparam int BEAT_W = LANE_W * PIXELS_PER_BEAT;
  localparam int KEEP_W = 2 * PIXELS_PER_BEAT;
  localparam int CNT_W  = (PIXELS_PER_BEAT > 1) ? $clog2(PIXELS_PER_BEAT) : 1;
  localparam int FIFO_W = BEAT_W + KEEP_W + 2;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    pack_cnt_q, pack_cnt_d, lane_idx;
  logic [BEAT_W-1:0]   lanes_q, lanes_d, beat_lanes;
  logic                sof_q, sof_d, beat_sof;
  logic                beat_valid_q, beat_valid_d;
  logic [BEAT_W-1:0]   beat_data_q, beat_data_d;
  logic [KEEP_W-1:0]   beat_keep_q, beat_keep_d;
  logic                beat_last_q, beat_last_d, beat_user_q, beat_user_d;
  logic                sof, lost, overflow_q;
  logic [15:0]         dropped_q;
  logic [FIFO_W-1:0]   fifo_rd_data;

  assign sof = s_axis_tvalid & s_axis_tuser;

  always_ff @(posedge axi4sclk or negedge axi4s_resetn) begin
    if (!axi4s_resetn) state_q <= SYNC;
    else               state_q <= state_d;
  end

  // A tuser pixel arriving in the very cycle a beat is lost starts the new
  // frame instead of being swallowed by DROP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SYNC, DROP: if (sof) state_d = PACK;
      PACK:       if (lost && !sof) state_d = DROP;
      default:    state_d = SYNC;
    endcase
  end

  always_comb begin
    pack_cnt_d   = pack_cnt_q;
    lanes_d      = lanes_q;
    sof_d        = sof_q;
    beat_valid_d = 1'b0;
    beat_data_d  = beat_data_q;
    beat_keep_d  = beat_keep_q;
    beat_last_d  = beat_last_q;
    beat_user_d  = beat_user_q;
    lane_idx     = '0;
    beat_lanes   = '0;
    beat_sof     = 1'b0;
    if (state_d != PACK) begin
      pack_cnt_d = '0;
      lanes_d    = '0;
      sof_d      = 1'b0;
    end else if (s_axis_tvalid) begin
      // tuser always restarts at lane 0, discarding any partial beat.
      lane_idx   = s_axis_tuser ? '0 : pack_cnt_q;
      beat_lanes = s_axis_tuser ? '0 : lanes_q;
      beat_lanes[int'(lane_idx)*LANE_W +: LANE_W] = LANE_W'(s_axis_tdata);
      beat_sof   = s_axis_tuser | sof_q;
      if (lane_idx == CNT_W'(PIXELS_PER_BEAT - 1) || s_axis_tlast) begin
        beat_valid_d = 1'b1;
        beat_data_d  = beat_lanes;
        for (int i = 0; i < KEEP_W; i++) beat_keep_d[i] = ((i / 2) <= int'(lane_idx));
        beat_last_d  = s_axis_tlast;
        beat_user_d  = beat_sof;
        pack_cnt_d   = '0;
        lanes_d      = '0;
        sof_d        = 1'b0;
      end else begin
        pack_cnt_d = CNT_W'(int'(lane_idx) + 1);
        lanes_d    = beat_lanes;
        sof_d      = beat_sof;
      end
    end
  end

  always_ff @(posedge axi4sclk or negedge axi4s_resetn) begin
    if (!axi4s_resetn) begin
      pack_cnt_q   <= '0;
      lanes_q      <= '0;
      sof_q        <= 1'b0;
      beat_valid_q <= 1'b0;
      beat_data_q  <= '0;
      beat_keep_q  <= '0;
      beat_last_q  <= 1'b0;
      beat_user_q  <= 1'b0;
      overflow_q   <= 1'b0;
      dropped_q    <= '0;
    end else begin
      pack_cnt_q   <= pack_cnt_d;
      lanes_q      <= lanes_d;
      sof_q        <= sof_d;
      beat_valid_q <= beat_valid_d;
      beat_data_q  <= beat_data_d;
      beat_keep_q  <= beat_keep_d;
      beat_last_q  <= beat_last_d;
      beat_user_q  <= beat_user_d;
      overflow_q   <= lost;
      if (lost && dropped_q != 16'hFFFF) dropped_q <= dropped_q + 16'd1;
    end
  end

  pixel_beat_fifo #(
    .DATA_W (FIFO_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (axi4sclk),
    .rst_n_i     (axi4s_resetn),
    .push_i      (beat_valid_q),
    .push_data_i ({beat_user_q, beat_last_q, beat_keep_q, beat_data_q}),
    .push_lost_o (lost),
    .rd_ready_i  (m_axis_tready),
    .rd_valid_o  (m_axis_tvalid),
    .rd_data_o   (fifo_rd_data)
  );

  assign {m_axis_tuser, m_axis_tlast, m_axis_tkeep, m_axis_tdata} = fifo_rd_data;
  assign overflow       = overflow_q;
  assign dropped_frames = dropped_q;

`ifdef MT9V034_PIXEL_PACKER_LINE_CHECK_EN
  logic [11:0] line_cnt_q, line_cnt_now;
  logic        line_err_q;

  assign line_cnt_now = s_axis_tuser ? 12'd1 : line_cnt_q + 12'd1;

  always_ff @(posedge axi4sclk or negedge axi4s_resetn) begin
    if (!axi4s_resetn) begin
      line_cnt_q <= '0;
      line_err_q <= 1'b0;
    end else begin
      line_err_q <= 1'b0;
      if (s_axis_tvalid) begin
        if (s_axis_tlast) begin
          line_cnt_q <= '0;
          line_err_q <= (cfg_line_pixels != 12'd0) && (line_cnt_now != cfg_line_pixels);
        end else begin
          line_cnt_q <= line_cnt_now;
        end
      end
    end
  end

  assign line_length_err = line_err_q;
`endif

endmodule

// File: tb/tb_mt9v034_pixel_packer.sv
module tb_mt9v034_pixel_packer;

  localparam int PW    = 10;
  localparam int PPB   = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0;
  logic [PW-1:0] s_tdata = '0;
  logic        m_tready = 1'b1;
  logic        m_tvalid, m_tlast, m_tuser, overflow;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic [15:0] dropped;

  always #5 clk = ~clk;

  mt9v034_pixel_packer #(
    .PIXEL_WIDTH     (PW),
    .PIXELS_PER_BEAT (PPB),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .axi4sclk       (clk),
    .axi4s_resetn   (rst_n),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tdata   (s_tdata),
    .s_axis_tlast   (s_tlast),
    .s_axis_tuser   (s_tuser),
    .m_axis_tready  (m_tready),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tdata   (m_tdata),
    .m_axis_tkeep   (m_tkeep),
    .m_axis_tlast   (m_tlast),
    .m_axis_tuser   (m_tuser),
    .overflow       (overflow),
    .dropped_frames (dropped)
  );

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
  } beat_t;

  int n_pass = 0, n_total = 0, ovf_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  beat_t       mq[$];      // beats visible/stored in the output FIFO
  beat_t       got[$];     // beats actually taken from the DUT
  beat_t       pend;
  bit          pend_v, in_frame, cur_sof, exp_ovf;
  int          exp_drop;
  logic [15:0] cur[$];

  function automatic beat_t mk(input bit last);
    beat_t b;
    b.d = '0;
    foreach (cur[i]) b.d = b.d | (64'(cur[i]) << (16 * i));
    b.k = 8'((1 << (2 * cur.size())) - 1);
    b.l = last;
    b.u = cur_sof;
    return b;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete(); cur.delete();
      pend_v = 0; in_frame = 0; cur_sof = 0; exp_ovf = 0; exp_drop = 0;
    end else begin
      if (m_tvalid && m_tready && mq.size() > 0) void'(mq.pop_front());
      exp_ovf = 0;
      if (pend_v) begin
        if (mq.size() < DEPTH) mq.push_back(pend);
        else begin
          exp_ovf = 1;
          if (exp_drop < 65535) exp_drop++;
          in_frame = 0; cur.delete(); cur_sof = 0;
        end
        pend_v = 0;
      end
      if (s_tvalid) begin
        if (s_tuser) begin in_frame = 1; cur.delete(); cur_sof = 1; end
        if (in_frame) begin
          cur.push_back(16'(s_tdata));
          if (cur.size() == PPB || s_tlast) begin
            pend = mk(s_tlast); pend_v = 1; cur.delete(); cur_sof = 0;
          end
        end
      end
    end
  end

  always @(posedge clk)
    if (rst_n && m_tvalid && m_tready) got.push_back({m_tdata, m_tkeep, m_tlast, m_tuser});

  always @(negedge clk) begin
    if (rst_n) begin
      chk("tvalid", 64'(m_tvalid), 64'(mq.size() != 0));
      if (m_tvalid && mq.size() != 0) begin
        chk("tdata", m_tdata, mq[0].d);
        chk("tkeep", 64'(m_tkeep), 64'(mq[0].k));
        chk("tlast", 64'(m_tlast), 64'(mq[0].l));
        chk("tuser", 64'(m_tuser), 64'(mq[0].u));
      end
      chk("overflow", 64'(overflow), 64'(exp_ovf));
      chk("dropped", 64'(dropped), 64'(exp_drop));
      if (overflow) ovf_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pix(input logic [PW-1:0] d, input bit l, input bit u);
    s_tvalid = 1; s_tdata = d; s_tlast = l; s_tuser = u;
    @(posedge clk); #1;
    s_tvalid = 0; s_tlast = 0; s_tuser = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain(input string name);
    int i;
    for (i = 0; i < 200; i++) begin
      if (mq.size() == 0 && !pend_v) break;
      @(posedge clk); #1;
    end
    idle(2);
    if (i >= 200) chk({name, "_timeout"}, 64'(i), 64'(0));
    chk({name, "_idle"}, 64'(m_tvalid), 64'(0));
  endtask

  task automatic chk_beat(input string name, input int idx, input logic [63:0] d,
                          input logic [7:0] k, input bit l, input bit u);
    if (idx >= got.size()) chk({name, "_missing"}, 64'(got.size()), 64'(idx + 1));
    else begin
      chk({name, "_d"}, got[idx].d, d);
      chk({name, "_k"}, 64'(got[idx].k), 64'(k));
      chk({name, "_l"}, 64'(got[idx].l), 64'(l));
      chk({name, "_u"}, 64'(got[idx].u), 64'(u));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tvalid", 64'(m_tvalid), 64'(0));
    chk("reset_dropped", 64'(dropped), 64'(0));
    rst_n = 1;
    idle(2);

    // Pixels before any tuser are ignored.
    pix(10'h3A1, 0, 0); pix(10'h3A2, 0, 0); pix(10'h3A3, 1, 0);
    idle(5);
    chk("presof_beats", 64'(got.size()), 64'(0));

    // Frame of 2 lines x 8 pixels.
    got.delete();
    for (int i = 1; i <= 16; i++) pix(PW'(i), (i == 8) || (i == 16), i == 1);
    drain("t1");
    chk("t1_count", 64'(got.size()), 64'(4));
    chk_beat("t1_b0", 0, 64'h0004_0003_0002_0001, 8'hFF, 0, 1);
    chk_beat("t1_b1", 1, 64'h0008_0007_0006_0005, 8'hFF, 1, 0);
    chk_beat("t1_b2", 2, 64'h000C_000B_000A_0009, 8'hFF, 0, 0);
    chk_beat("t1_b3", 3, 64'h0010_000F_000E_000D, 8'hFF, 1, 0);

    // Line of 6 pixels: partial last beat.
    got.delete();
    for (int i = 1; i <= 6; i++) pix(PW'(10'h20 + i), i == 6, i == 1);
    drain("t2");
    chk("t2_count", 64'(got.size()), 64'(2));
    chk_beat("t2_b0", 0, 64'h0024_0023_0022_0021, 8'hFF, 0, 1);
    chk_beat("t2_b1", 1, 64'h0000_0000_0026_0025, 8'h0F, 1, 0);

    // tuser after two lanes: partial beat discarded.
    got.delete();
    pix(10'h31, 0, 1); pix(10'h32, 0, 0);
    pix(10'h41, 0, 1); pix(10'h42, 0, 0); pix(10'h43, 0, 0); pix(10'h44, 1, 0);
    drain("t5");
    chk("t5_count", 64'(got.size()), 64'(1));
    chk_beat("t5_b0", 0, 64'h0044_0043_0042_0041, 8'hFF, 1, 1);

    // Overflow with tready held low.
    got.delete();
    m_tready = 0;
    ovf_cnt = 0;
    for (int i = 1; i <= 24; i++) pix(PW'(10'h100 + i), (i % 8) == 0, i == 1);
    idle(4);
    chk("t3_ovf_pulses", 64'(ovf_cnt), 64'(1));
    chk("t3_dropped", 64'(dropped), 64'(1));
    m_tready = 1;
    drain("t3");
    chk("t3_drained", 64'(got.size()), 64'(4));
    chk_beat("t3_b0", 0, 64'h0104_0103_0102_0101, 8'hFF, 0, 1);
    chk_beat("t3_b3", 3, 64'h0110_010F_010E_010D, 8'hFF, 1, 0);
    pix(10'h1F1, 0, 0); pix(10'h1F2, 0, 0); pix(10'h1F3, 0, 0); pix(10'h1F4, 1, 0);
    idle(5);
    chk("t3_drop_quiet", 64'(got.size()), 64'(4));
    for (int i = 1; i <= 8; i++) pix(PW'(10'h200 + i), i == 8, i == 1);
    drain("t3r");
    chk("t3_recover", 64'(got.size()), 64'(6));
    chk_beat("t3_b4", 4, 64'h0204_0203_0202_0201, 8'hFF, 0, 1);
    chk_beat("t3_b5", 5, 64'h0208_0207_0206_0205, 8'hFF, 1, 0);

    // Reset mid-frame with three beats buffered.
    got.delete();
    m_tready = 0;
    for (int i = 1; i <= 12; i++) pix(PW'(10'h300 + i), 0, i == 1);
    idle(3);
    chk("t6_buffered", 64'(m_tvalid), 64'(1));
    #1 rst_n = 0;
    #1 chk("t6_tvalid_async", 64'(m_tvalid), 64'(0));
    chk("t6_dropped_rst", 64'(dropped), 64'(0));
    @(posedge clk); #1;
    rst_n = 1;
    m_tready = 1;
    idle(2);
    pix(10'h355, 0, 0); pix(10'h356, 1, 0);
    idle(5);
    chk("t6_sync_quiet", 64'(got.size()), 64'(0));
    pix(10'h61, 0, 1); pix(10'h62, 0, 0); pix(10'h63, 0, 0); pix(10'h64, 1, 0);
    drain("t6");
    chk("t6_count", 64'(got.size()), 64'(1));
    chk_beat("t6_b0", 0, 64'h0064_0063_0062_0061, 8'hFF, 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
